// File: rtl/rom_row_fetcher_pkg.sv
// Shared types and sizing for the coefficient ROM row fetcher.
// Imported by the serializer and the top-level fetcher.
package rom_fetch_pkg;

  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned BYTE_W_DEF     = 8;
  localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / BYTE_W_DEF;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/rom_row_fetcher_if.sv
// Tagged valid/ready byte stream from the fetcher to the MAC/FIFO fill stage.
// The master drives data and tags; the slave drives ready.
interface rom_row_fetcher_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned LANE_W = 3
);

  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic [ADDR_W-1:0] out_word;
  logic [LANE_W-1:0] out_byte;
  logic              out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_word,
    output out_byte,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_word,
    input  out_byte,
    input  out_last
  );

endinterface

// File: rtl/rom_row_fetcher_word_serializer.sv
// Holds one captured ROM word and shifts it out MSB byte first on a valid/ready handshake.
// Valid rises on load and drops after the last lane is accepted.
module word_serializer
  import rom_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [BYTE_W-1:0] data_o,
  output logic [LANE_W-1:0] lane_o,
  output logic              last_lane_o,
  output logic              word_done_o
);

  localparam int unsigned Lanes = DATA_W / BYTE_W;

  logic [DATA_W-1:0] word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              valid_q, valid_d;
  logic              handshake;

  assign handshake   = valid_q && ready_i;
  assign last_lane_o = (lane_q == LANE_W'(Lanes - 1));
  assign word_done_o = handshake && last_lane_o;
  assign valid_o     = valid_q;
  assign data_o      = word_q[DATA_W-1 -: BYTE_W];
  assign lane_o      = lane_q;

  always_comb begin
    word_d  = word_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = load_data_i;
      lane_d  = '0;
      valid_d = 1'b1;
    end else if (handshake) begin
      word_d = word_q << BYTE_W;
      lane_d = lane_q + LANE_W'(1);
      if (last_lane_o) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rom_row_fetcher.sv
// Walks the coefficient ROM from address 0 to NUM_WORDS-1, absorbing its one-cycle read
// latency, and streams every word out as tagged bytes.
module rom_row_fetcher
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_WORDS = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  rom_row_fetcher_if.master out_if
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;

  logic              ser_load;
  logic              ser_valid;
  logic [BYTE_W-1:0] ser_data;
  logic [LANE_W-1:0] ser_lane;
  logic              ser_last_lane;
  logic              ser_word_done;
  logic              last_word;

  assign last_word = (word_idx_q == ADDR_W'(NUM_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    ser_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          word_idx_d = '0;
        end
      end
      // The ROM registers rom_address at the edge that leaves this state.
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_word_done) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            word_idx_d = word_idx_q + ADDR_W'(1);
            state_d    = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
    end
  end

  word_serializer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_serializer (
    .clock       (clock),
    .reset       (reset),
    .load_i      (ser_load),
    .load_data_i (rom_q),
    .ready_i     (out_if.out_ready),
    .valid_o     (ser_valid),
    .data_o      (ser_data),
    .lane_o      (ser_lane),
    .last_lane_o (ser_last_lane),
    .word_done_o (ser_word_done)
  );

  assign rom_address = word_idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  assign out_if.out_valid = ser_valid;
  assign out_if.out_data  = ser_data;
  assign out_if.out_word  = word_idx_q;
  assign out_if.out_byte  = ser_lane;
  assign out_if.out_last  = ser_valid && last_word && ser_last_lane;

endmodule

// File: tb/tb_rom_row_fetcher.sv
// Scoreboard bench for rom_row_fetcher: a registered ROM model, randomized backpressure,
// and an independent monitor comparing every accepted byte with a queued expectation.
module tb_rom_row_fetcher;

  typedef struct packed {
    logic [7:0] d;
    logic [4:0] w;
    logic [2:0] b;
    logic       l;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rom_address;
  logic [63:0] rom_q;

  logic [63:0] rom_mem [9];
  exp_t        exp_q [$];
  int          checks;
  int          errors;
  int          done_cnt;
  int          done_exp;
  bit          rand_ready;

  rom_row_fetcher_if #(.ADDR_W(5), .BYTE_W(8), .LANE_W(3)) bus ();

  rom_row_fetcher #(
    .ADDR_W    (5),
    .DATA_W    (64),
    .BYTE_W    (8),
    .NUM_WORDS (9)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .out_if      (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read ROM, one cycle of latency.
  always @(posedge clock) begin
    rom_q <= (rom_address < 5'd9) ? rom_mem[rom_address] : 64'h0;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_run();
    exp_t e;
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 8; b++) begin
        e.d = 8'((rom_mem[w] >> (8 * (7 - b))) & 64'hFF);
        e.w = 5'(w);
        e.b = 3'(b);
        e.l = (w == 8) && (b == 7);
        exp_q.push_back(e);
      end
    end
    done_exp++;
  endtask

  // Monitor: sample between edges; a handshake seen here completes at the next posedge.
  exp_t held;
  bit   stall_prev;
  always @(negedge clock) begin
    exp_t cur;
    exp_t e;
    cur = '{d: bus.out_data, w: bus.out_word, b: bus.out_byte, l: bus.out_last};
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", 64'(bus.out_valid), 64'd1);
        chk("stall_fields_held", 64'(cur), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 64'(cur), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("byte{data,word,lane,last}", 64'(cur), 64'(e));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = cur;
      if (done) begin
        done_cnt++;
        chk("done_after_last_byte", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic do_run(input bit timing, input bit poke);
    int n;
    push_run();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 1;
    if (timing) begin
      chk("issue_busy", 64'(busy), 64'd1);
      chk("issue_rom_address", 64'(rom_address), 64'd0);
      chk("issue_out_valid", 64'(bus.out_valid), 64'd0);
    end
    while (!done && n < 3000) begin
      if (poke) start = 1'($urandom_range(0, 1));
      if (timing && n == 2) chk("capture_out_valid", 64'(bus.out_valid), 64'd0);
      if (timing && n == 3) begin
        chk("first_out_valid", 64'(bus.out_valid), 64'd1);
        chk("first_out_data", 64'(bus.out_data), 64'h01);
      end
      @(posedge clock);
      #1;
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (timing) chk("done_cycle", 64'(n), 64'd91);
    chk("done_busy", 64'(busy), 64'd1);
    start = poke;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
    if (poke) begin
      @(posedge clock);
      #1;
      chk("start_in_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    done_exp   = 0;
    rand_ready = 1'b0;
    stall_prev = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 8; b++) begin
        rom_mem[w][63 - 8 * b -: 8] = 8'((w << 4) | (b + 1));
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_rom_address", 64'(rom_address), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Full-rate run with latency checks.
    do_run(1'b1, 1'b0);

    // Random backpressure, start hammered while busy and in the DONE cycle.
    rand_ready = 1'b1;
    do_run(1'b0, 1'b1);

    // Reset in the middle of word 4, right after 0x43 is accepted.
    rand_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    push_run();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (!(bus.out_valid && bus.out_data == 8'h44) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("reached_byte_0x44", 64'(bus.out_data), 64'h44);
    reset = 1'b1;
    exp_q.delete();
    done_exp--;
    @(posedge clock);
    #1;
    chk("midrun_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_rom_address", 64'(rom_address), 64'd0);
    chk("midrun_reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Replay from 0x01, then a back-to-back run under random backpressure.
    do_run(1'b1, 1'b0);
    rand_ready = 1'b1;
    do_run(1'b0, 1'b0);

    repeat (5) @(posedge clock);
    #1;
    chk("leftover_expected_bytes", 64'(exp_q.size()), 64'd0);
    chk("done_pulse_count", 64'(done_cnt), 64'(done_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
